// File: rtl/t9990_scan_doubler.sv
// t9990_scan_doubler
//   Line-doubling scan converter that sits after the tiny9990 top. In the 15 kHz modes
//   (RESO 0-3) each input line is written into one of two line banks while the previous
//   line is replayed twice from the other bank at the 2x dot rate, giving a 31 kHz stream.
//   31 kHz modes (RESO 4-5), or ENABLE=0, pass the input through with one register stage.
// Ports
//   CLK, RESET_n          system clock, synchronous active-low reset
//   DCLK_EN / DCLK2_EN    input dot enable / output dot enable (two pulses per input dot)
//   ENABLE, RESO          doubling enable and resolution code (mode sampled at IN_VS rise)
//   IN_HS/VS/R/G/B/YS     input syncs and pixel from tiny9990
//   OUT_HS/VS/R/G/B/YS    output syncs and pixel, qualified by OUT_DCLK_EN
//   OUT_DCLK_EN           output dot strobe, aligned with the output data registers
//   BYPASS                1 while the pass-through path drives the outputs
module t9990_scan_doubler #(
  parameter int LINE_MAX = 1024,
  parameter int XW       = 10
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       DCLK_EN,
  input  logic       DCLK2_EN,
  input  logic       ENABLE,
  input  logic [2:0] RESO,
  input  logic       IN_HS,
  input  logic       IN_VS,
  input  logic [4:0] IN_R,
  input  logic [4:0] IN_G,
  input  logic [4:0] IN_B,
  input  logic       IN_YS,
  output logic       OUT_HS,
  output logic       OUT_VS,
  output logic [4:0] OUT_R,
  output logic [4:0] OUT_G,
  output logic [4:0] OUT_B,
  output logic       OUT_YS,
  output logic       OUT_DCLK_EN,
  output logic       BYPASS
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_LINE0 = 2'd1;
  localparam logic [1:0]    S_LINE1 = 2'd2;
  localparam logic [1:0]    S_HOLD  = 2'd3;
  localparam logic [XW:0]   LEN_MAX = (XW+1)'(LINE_MAX);
  localparam logic [XW-1:0] X_LAST  = XW'(LINE_MAX-1);

  // Two banks of LINE_MAX words, addressed {bank, x}; word = {Ys, G, R, B}
  logic [15:0] mem [2*LINE_MAX];
  logic [15:0] rdata_q;

  logic          hs_prev_q, vs_prev_q, wb_q, wr_full_q, bypass_q;
  logic          vs_lat_q, line_ok_q, blank_q;
  logic [XW-1:0] wr_x_q, rd_x_q;
  logic [XW:0]   line_len_q, hs_len_q, hs_w_q;
  logic [1:0]    st_q;
  logic          p1_vld_q, p1_hs_q, p1_vs_q, p1_blank_q;
  logic [17:0]   out_q;        // {hs, vs, ys, g, r, b}
  logic          odclk_q;

  logic          hs_edge, vs_rise, want_bypass, mode_chg, restart;
  logic          we, active, x_last;
  logic [XW:0]   wr_len;
  logic [1:0]    st_eff;
  logic [XW-1:0] x_eff;
  logic          rb_eff, blank_eff, vs_eff;
  logic [XW:0]   len_eff, hslen_eff;

  assign hs_edge     = DCLK_EN && IN_HS && !hs_prev_q;
  assign vs_rise     = DCLK_EN && IN_VS && !vs_prev_q;
  assign want_bypass = !ENABLE || (RESO >= 3'd4);
  assign mode_chg    = vs_rise && (want_bypass != bypass_q);
  assign restart     = hs_edge && !mode_chg;
  // Once address LINE_MAX-1 has been written the rest of the line is dropped
  assign we          = DCLK_EN && !wr_full_q;
  assign wr_len      = {1'b0, wr_x_q} + (XW+1)'(1);

  // Read-side view for this cycle. An HS edge that coincides with DCLK2_EN must already
  // read dot 0 of the freshly completed bank, so the restart values are forwarded here.
  always_comb begin
    st_eff    = st_q;
    x_eff     = rd_x_q;
    rb_eff    = !wb_q;
    blank_eff = blank_q;
    vs_eff    = vs_lat_q;
    len_eff   = line_len_q;
    hslen_eff = hs_len_q;
    if (mode_chg) begin
      st_eff = S_IDLE;
      x_eff  = '0;
    end else if (restart) begin
      st_eff    = S_LINE0;
      x_eff     = '0;
      rb_eff    = wb_q;          // bank that is about to become the read bank
      blank_eff = !line_ok_q;
      vs_eff    = IN_VS;
      len_eff   = wr_len;
      hslen_eff = hs_w_q;
    end
  end

  assign active = (st_eff == S_LINE0) || (st_eff == S_LINE1);
  assign x_last = ({1'b0, x_eff} == len_eff - (XW+1)'(1));

  always_ff @(posedge CLK) begin
    if (we) mem[{wb_q, wr_x_q}] <= {IN_YS, IN_G, IN_R, IN_B};
    rdata_q <= mem[{rb_eff, x_eff}];
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      wb_q       <= 1'b0;
      wr_full_q  <= 1'b0;
      bypass_q   <= 1'b1;
      vs_lat_q   <= 1'b0;
      line_ok_q  <= 1'b0;
      blank_q    <= 1'b0;
      wr_x_q     <= '0;
      rd_x_q     <= '0;
      line_len_q <= '0;
      hs_len_q   <= '0;
      hs_w_q     <= '0;
      st_q       <= S_IDLE;
      p1_vld_q   <= 1'b0;
      p1_hs_q    <= 1'b0;
      p1_vs_q    <= 1'b0;
      p1_blank_q <= 1'b0;
      out_q      <= '0;
      odclk_q    <= 1'b0;
    end else begin
      // write side
      if (DCLK_EN) begin
        hs_prev_q <= IN_HS;
        vs_prev_q <= IN_VS;
      end
      if (vs_rise) bypass_q <= want_bypass;
      if (hs_edge) begin
        // the edge dot closes the old line (it is written at wr_x above)
        line_len_q <= wr_len;
        hs_len_q   <= hs_w_q;
        wr_x_q     <= '0;
        wr_full_q  <= 1'b0;
        wb_q       <= !wb_q;
        vs_lat_q   <= IN_VS;
        hs_w_q     <= (XW+1)'(1);
      end else if (DCLK_EN) begin
        if (!wr_full_q) begin
          if (wr_x_q == X_LAST) wr_full_q <= 1'b1;
          else                  wr_x_q    <= wr_x_q + XW'(1);
        end
        if (IN_HS && (hs_w_q < LEN_MAX)) hs_w_q <= hs_w_q + (XW+1)'(1);
      end

      // the first line after IDLE replays a bank that was never filled: keep it black
      if (mode_chg) begin
        line_ok_q <= 1'b0;
      end else if (restart) begin
        line_ok_q <= 1'b1;
        blank_q   <= !line_ok_q;
      end

      // read side
      if (DCLK2_EN && active) begin
        if (x_last) begin
          rd_x_q <= '0;
          st_q   <= (st_eff == S_LINE0) ? S_LINE1 : S_HOLD;
        end else begin
          rd_x_q <= x_eff + XW'(1);
          st_q   <= st_eff;
        end
      end else begin
        rd_x_q <= x_eff;
        st_q   <= st_eff;
      end

      // stage 1: travels alongside the RAM read. VS in HOLD equals vs_lat because
      // vs_lat only changes on an HS edge, which always leaves HOLD.
      p1_vld_q   <= DCLK2_EN;
      p1_hs_q    <= active && !blank_eff && ({1'b0, x_eff} < hslen_eff);
      p1_vs_q    <= (st_eff != S_IDLE) && vs_eff;
      p1_blank_q <= !active || blank_eff;

      // stage 2: output registers
      if (bypass_q) begin
        odclk_q <= DCLK_EN;
        if (DCLK_EN) out_q <= {IN_HS, IN_VS, IN_YS, IN_G, IN_R, IN_B};
      end else begin
        odclk_q <= p1_vld_q;
        if (p1_vld_q) out_q <= {p1_hs_q, p1_vs_q, p1_blank_q ? 16'h0000 : rdata_q};
      end
    end
  end

  assign OUT_HS      = out_q[17];
  assign OUT_VS      = out_q[16];
  assign OUT_YS      = out_q[15];
  assign OUT_G       = out_q[14:10];
  assign OUT_R       = out_q[9:5];
  assign OUT_B       = out_q[4:0];
  assign OUT_DCLK_EN = odclk_q;
  assign BYPASS      = bypass_q;

endmodule

// File: tb/tb_t9990_scan_doubler.sv
// Testbench for t9990_scan_doubler. Dot timing: DCLK_EN on one clock of every four,
// DCLK2_EN on the two clocks between. The reference model works per line: it keeps the
// dots received since the last HS edge, and for each output slot emits the replayed
// line by slot index (2 x length, then black) or the pass-through pixel in bypass.
module tb_t9990_scan_doubler;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET_n, DCLK_EN, DCLK2_EN, ENABLE;
  logic [2:0] RESO;
  logic       IN_HS, IN_VS, IN_YS;
  logic [4:0] IN_R, IN_G, IN_B;
  logic       OUT_HS, OUT_VS, OUT_YS, OUT_DCLK_EN, BYPASS;
  logic [4:0] OUT_R, OUT_G, OUT_B;

  t9990_scan_doubler dut (
    .CLK(CLK), .RESET_n(RESET_n), .DCLK_EN(DCLK_EN), .DCLK2_EN(DCLK2_EN),
    .ENABLE(ENABLE), .RESO(RESO), .IN_HS(IN_HS), .IN_VS(IN_VS),
    .IN_R(IN_R), .IN_G(IN_G), .IN_B(IN_B), .IN_YS(IN_YS),
    .OUT_HS(OUT_HS), .OUT_VS(OUT_VS), .OUT_R(OUT_R), .OUT_G(OUT_G), .OUT_B(OUT_B),
    .OUT_YS(OUT_YS), .OUT_DCLK_EN(OUT_DCLK_EN), .BYPASS(BYPASS)
  );

  int checks = 0;
  int failures = 0;
  logic [17:0] expq[$];   // {hs, vs, ys, g, r, b}

  // reference model state
  bit          m_byp, m_idle, m_have, m_blank, m_vsl, prev_hs, prev_vs;
  logic [15:0] seg[$];
  logic [15:0] line_buf[$];
  int          hscnt, m_len, m_hslen, slot;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_byp = 1; m_idle = 1; m_have = 0; m_blank = 0; m_vsl = 0;
    prev_hs = 0; prev_vs = 0;
    seg.delete(); line_buf.delete();
    hscnt = 0; m_len = 1; m_hslen = 0; slot = 0;
    expq.delete();
  endtask

  task automatic model_dot(input logic hs, input logic vs, input logic [15:0] pix);
    logic [15:0] nl[$];
    int  nlh;
    bit  edge_, vsr, want, chg;
    edge_ = hs && !prev_hs;
    vsr   = vs && !prev_vs;
    prev_hs = hs; prev_vs = vs;
    nlh = 0;
    if (m_byp) expq.push_back({hs, vs, pix});
    if (seg.size() < 1024) seg.push_back(pix);
    if (edge_) begin
      nl = seg; nlh = hscnt; seg.delete(); hscnt = 1;
    end else if (hs && hscnt < 1024) hscnt++;
    chg = 0;
    if (vsr) begin
      want  = !ENABLE || (RESO >= 4);
      chg   = (want != m_byp);
      m_byp = want;
    end
    if (chg) begin
      m_idle = 1; m_have = 0;
    end else if (edge_) begin
      m_idle = 0; line_buf = nl; m_len = nl.size(); m_hslen = nlh;
      m_vsl = vs; m_blank = !m_have; m_have = 1; slot = 0;
    end
  endtask

  task automatic model_slot();
    logic [17:0] e;
    int x;
    if (!m_byp) begin
      if (m_idle) e = '0;
      else if (slot < 2*m_len) begin
        x = slot % m_len;
        if (m_blank) e = {1'b0, m_vsl, 16'h0000};
        else         e = {1'(x < m_hslen), m_vsl, line_buf[x]};
      end else e = {1'b0, m_vsl, 16'h0000};
      if (!m_idle) slot++;
      expq.push_back(e);
    end
  endtask

  task automatic dot(input logic hs, input logic vs, input logic [15:0] pix);
    @(negedge CLK);
    DCLK2_EN = 0; DCLK_EN = 1; IN_HS = hs; IN_VS = vs;
    {IN_YS, IN_G, IN_R, IN_B} = pix;
    model_dot(hs, vs, pix);
    @(negedge CLK); DCLK_EN = 0; DCLK2_EN = 1; model_slot();
    @(negedge CLK); DCLK2_EN = 0;
    @(negedge CLK); DCLK2_EN = 1; model_slot();
  endtask

  task automatic mid_reset();
    @(negedge CLK);
    DCLK_EN = 0; DCLK2_EN = 0; RESET_n = 0;
    @(negedge CLK);
    chk("midrst_out", {OUT_HS, OUT_VS, OUT_YS, OUT_G, OUT_R, OUT_B, OUT_DCLK_EN}, 0);
    chk("midrst_bypass", BYPASS, 1);
    repeat (2) @(negedge CLK);
    model_reset();
    RESET_n = 1;
  endtask

  task automatic send_line(input int n, input int w, input logic vs, input bit ramp, input int rst_at);
    for (int d = 0; d < n; d++) begin
      dot(1'(d < w), vs, ramp ? 16'(d) : 16'($urandom));
      if (d == rst_at) mid_reset();
    end
    chk("bypass", BYPASS, m_byp);
  endtask

  task automatic frame(input int nl, input int lo, input int hi);
    for (int l = 0; l < nl; l++)
      send_line($urandom_range(hi, lo), $urandom_range(12, 1), 1'(l < 3), 0, -1);
  endtask

  // output monitor / scoreboard
  always @(negedge CLK) begin
    if (RESET_n && OUT_DCLK_EN) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out: got %0h expected no output at %0t",
                 {OUT_HS, OUT_VS, OUT_YS, OUT_G, OUT_R, OUT_B}, $time);
      end else begin
        chk("out_dot", {14'h0, OUT_HS, OUT_VS, OUT_YS, OUT_G, OUT_R, OUT_B}, {14'h0, expq.pop_front()});
      end
    end
  end

  initial begin
    RESET_n = 0; DCLK_EN = 0; DCLK2_EN = 0; ENABLE = 1; RESO = 0;
    IN_HS = 0; IN_VS = 0; IN_YS = 0; IN_R = 0; IN_G = 0; IN_B = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_hs", OUT_HS, 0);  chk("rst_vs", OUT_VS, 0);
    chk("rst_r", OUT_R, 0);    chk("rst_g", OUT_G, 0);
    chk("rst_b", OUT_B, 0);    chk("rst_ys", OUT_YS, 0);
    chk("rst_dclk", OUT_DCLK_EN, 0); chk("rst_bypass", BYPASS, 1);
    RESET_n = 1;

    // 15 kHz doubling with a ramp: IDLE, black line, then real replays
    for (int l = 0; l < 4; l++) send_line(342, 26, 1'(l < 3), 1, -1);
    // random lines; RESO switches to a 31 kHz code mid-frame without effect yet
    for (int l = 0; l < 8; l++) begin
      if (l == 4) RESO = 4;
      send_line($urandom_range(90, 16), $urandom_range(12, 1), 1'(l < 3), 0, -1);
    end
    RESO = 5;                 // bypass from this frame's VS rise
    frame(6, 16, 60);
    ENABLE = 0; RESO = 0;     // still bypass, no mode change
    frame(4, 16, 60);
    ENABLE = 1; RESO = 1;     // back to doubling; overlong lines saturate at 1024
    send_line(40, 8, 1, 0, -1);
    send_line(1100, 50, 1, 0, -1);
    send_line(1100, 50, 1, 0, -1);
    send_line(1030, 20, 0, 0, -1);
    send_line(60, 5, 0, 0, -1);
    send_line(30, 4, 0, 0, -1);
    send_line(200, 12, 0, 0, -1);
    send_line(300, 12, 0, 0, 150);   // reset while replaying the 200-dot line a second time
    RESO = 2;
    frame(6, 16, 90);
    frame(4, 16, 90);

    @(negedge CLK);
    DCLK_EN = 0; DCLK2_EN = 0;
    repeat (10) @(negedge CLK);
    chk("drain", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
